seq_shift_right_unit: RTL



---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_step.sv | 29 ++
 rtl/seq_shift_right_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the sequential shifter: FSM encoding, shamt width, op codes.
// Left shifts exist only when SEQ_SHIFT_LEFT_EN is defined.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_SRL = 2'd0;
    localparam logic [1:0] OP_SRA = 2'd1;
    localparam logic [1:0] OP_SLL = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One combinational step of the shifter: moves value by k (at most STEP) bits.
// The left path and dir port exist only when SEQ_SHIFT_LEFT_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int KW = 1
) (
    input  logic [XLEN-1:0] value,
    input  logic [KW-1:0]   k,
    input  logic            fill_bit,
`ifdef SEQ_SHIFT_LEFT_EN
    input  logic            dir,
`endif
    output logic [XLEN-1:0] shifted
);

    logic [XLEN-1:0] fill_mask;

    always_comb begin
        fill_mask = ~({XLEN{1'b1}} >> k);
        shifted   = (value >> k) | (fill_bit ? fill_mask : '0);
`ifdef SEQ_SHIFT_LEFT_EN
        if (dir) begin
            shifted = value << k;
        end
`endif
    end

endmodule

// File: rtl/seq_shift_right_unit.sv
// Multi-cycle RV32I SRL/SRA unit, STEP bits per cycle, valid/ready on both sides.
// Optional SLL support is enabled with SEQ_SHIFT_LEFT_EN.
module seq_shift_right_unit
    import shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
`ifdef SEQ_SHIFT_LEFT_EN
    input  logic               left,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result
);

    localparam int KW = $clog2(STEP) + 1;
    localparam logic [SHAMT_W-1:0] STEP_W = SHAMT_W'(STEP);

    logic [1:0]         state;
    logic [SHAMT_W-1:0] remain;
    logic               sgn;
    logic [SHAMT_W-1:0] k_full;
    logic [SHAMT_W-1:0] remain_next;
    logic [XLEN-1:0]    shifted;
`ifdef SEQ_SHIFT_LEFT_EN
    logic               dir;
`endif

    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign k_full      = (remain < STEP_W) ? remain : STEP_W;
    assign remain_next = remain - k_full;

    // MSB is invariant under SRA, so the live bit 31 is the original sign
    shift_step #(
        .KW(KW)
    ) u_step (
        .value   (result),
        .k       (k_full[KW-1:0]),
        .fill_bit(sgn & result[XLEN-1]),
`ifdef SEQ_SHIFT_LEFT_EN
        .dir     (dir),
`endif
        .shifted (shifted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            remain <= '0;
            sgn    <= 1'b0;
            result <= '0;
`ifdef SEQ_SHIFT_LEFT_EN
            dir    <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        result <= operand;
                        remain <= shamt;
                        sgn    <= arith;
`ifdef SEQ_SHIFT_LEFT_EN
                        dir    <= left;
`endif
                        state  <= (shamt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    result <= shifted;
                    remain <= remain_next;
                    if (remain_next == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
